// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and
// load/store. Data has priority, fetch has a starvation guard, and a watchdog aborts hung accesses.
module unified_mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          bus_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state;
    logic [SW-1:0] starveCnt;
    logic [WW-1:0] waitCnt;
    logic          busy;
    logic          memDone;
    logic          timedOut;
    logic          finish;
    logic          grantDm;
    logic          grantIf;

    always_comb begin
        busy     = (state != IDLE);
        // A response during the issue cycle cannot belong to this access.
        memDone  = busy && mem_valid && !mem_en;
        timedOut = busy && !memDone && (waitCnt == WW'(TIMEOUT_CYC));
        finish   = memDone || timedOut;
        grantDm  = dm_req && (!if_req || (starveCnt < SW'(STARVE_LIMIT)));
        grantIf  = if_req && !grantDm;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            waitCnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantDm) begin
                        state     <= BUSY_DM;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        waitCnt   <= '0;
                        if (!if_req)
                            starveCnt <= '0;
                        else if (starveCnt != SW'(STARVE_LIMIT))
                            starveCnt <= starveCnt + 1'b1;
                    end else if (grantIf) begin
                        state     <= BUSY_IF;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        waitCnt   <= '0;
                        starveCnt <= '0;
                    end
                end
                default: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (finish) begin
                        state <= IDLE;
                        if (timedOut)
                            bus_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        if_ready  = (state == BUSY_IF) && finish;
        dm_ready  = (state == BUSY_DM) && finish;
        if_rdata  = ((state == BUSY_IF) && memDone) ? mem_rdata : '0;
        dm_rdata  = ((state == BUSY_DM) && memDone && !mem_we) ? mem_rdata : '0;
        stall_if  = if_req & ~if_ready;
        stall_mem = dm_req & ~dm_ready;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: stimulus queues expected issues/responses,
// a negedge monitor pops and compares them whenever the DUT strobes mem_en or a ready.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, mem_valid;
    logic        stall_if, stall_mem, bus_err;

    logic        respValid = 1'b0, staleValid = 1'b0;
    logic [31:0] respData = '0, staleData = '0;
    assign mem_valid = respValid | staleValid;
    assign mem_rdata = respValid ? respData : staleData;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } issue_t;
    typedef struct packed { logic isDm; logic [31:0] rdata; } resp_t;

    issue_t expIssue[$];
    resp_t  expResp[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     memLat = 1;
    bit     memMute = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushIssue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        issue_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        expIssue.push_back(e);
    endtask

    task automatic pushResp(input logic isDm, input logic [31:0] rdata);
        resp_t r;
        r.isDm = isDm; r.rdata = rdata;
        expResp.push_back(r);
    endtask

    task automatic waitReady(input bit dm, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(dm ? dm_ready : if_ready) && cnt < limit);
        if (!(dm ? dm_ready : if_ready)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_%s: no ready within %0d cycles", dm ? "dm" : "if", limit);
        end
    endtask

    // Memory model: returns ~addr after memLat cycles, unless muted.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (reset && mem_en && !memMute) begin
                a = mem_addr;
                repeat (memLat) @(posedge clk);
                #1 respValid = 1'b1; respData = ~a;
                @(posedge clk);
                #1 respValid = 1'b0; respData = '0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_en) begin
                issue_t e;
                vectors++;
                if (expIssue.size() == 0) begin
                    miscompares++;
                    $display("FAIL issue: unexpected mem_en got we=%b addr=%h", mem_we, mem_addr);
                end else begin
                    e = expIssue.pop_front();
                    if ({mem_we, mem_addr} !== {e.we, e.addr} || (e.we && mem_wdata !== e.wdata)) begin
                        miscompares++;
                        $display("FAIL issue: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                    end
                end
            end
            if (if_ready || dm_ready) begin
                resp_t r;
                vectors++;
                if (expResp.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp: unexpected ready got if_ready=%b dm_ready=%b", if_ready, dm_ready);
                end else begin
                    r = expResp.pop_front();
                    if ({if_ready, dm_ready, if_rdata, dm_rdata} !==
                        {!r.isDm, r.isDm, r.isDm ? 32'h0 : r.rdata, r.isDm ? r.rdata : 32'h0}) begin
                        miscompares++;
                        $display("FAIL resp: got if_ready=%b dm_ready=%b if_rdata=%h dm_rdata=%h expected port=%s rdata=%h",
                                 if_ready, dm_ready, if_rdata, dm_rdata, r.isDm ? "dm" : "if", r.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int dmIdx;
        int ifIdx;
        int budget;
        bit gotDm;
        bit gotIf;

        reset = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset state
        @(negedge clk);
        check("reset outs", {mem_en, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, bus_err}, '0);
        check("reset rdata", {if_rdata, dm_rdata}, '0);
        @(negedge clk);
        reset = 1'b1;

        // Single fetch, latency 1
        @(posedge clk); #1;
        memLat = 1; if_req = 1'b1; if_addr = 32'h100;
        pushIssue(1'b0, 32'h100, '0); pushResp(1'b0, 32'hFFFF_FEFF);
        @(negedge clk); check("t1 stall_if c0", stall_if, 1);
        @(negedge clk); check("t1 stall_if c1", stall_if, 1); check("t1 mem_en c1", mem_en, 1);
        @(negedge clk); check("t1 if_ready c2", if_ready, 1); check("t1 stall_if c2", stall_if, 0);
        @(posedge clk); #1 if_req = 1'b0;

        // Simultaneous requests: DM first, IF in next IDLE
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        pushIssue(1'b0, 32'h2000, '0); pushIssue(1'b0, 32'h300, '0);
        pushResp(1'b1, 32'hFFFF_DFFF); pushResp(1'b0, 32'hFFFF_FCFF);
        waitReady(1'b1, 20, n);
        check("t2 dm latency", n, 3);
        check("t2 stall_if at dm_ready", stall_if, 1);
        check("t2 stall_mem at dm_ready", stall_mem, 0);
        @(posedge clk); #1 dm_req = 1'b0;
        check("t2 stall_if between", stall_if, 1);
        waitReady(1'b0, 20, n);
        check("t2 if follows", n, 3);
        @(posedge clk); #1 if_req = 1'b0;

        // Starvation guard: 4 DM, IF, 4 DM, IF, DM
        for (int i = 0; i < 9; i++) begin
            if (i == 4) pushIssue(1'b0, 32'h500, '0);
            if (i == 8) pushIssue(1'b0, 32'h600, '0);
            pushIssue(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        for (int i = 0; i < 9; i++) begin
            if (i == 4) pushResp(1'b0, 32'hFFFF_FAFF);
            if (i == 8) pushResp(1'b0, 32'hFFFF_F9FF);
            pushResp(1'b1, 32'h0);
        end
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hA000_0000;
        if_req = 1'b1; if_addr = 32'h500;
        dmIdx = 0; ifIdx = 0; budget = 0;
        while ((dmIdx < 9 || ifIdx < 2) && budget < 200) begin
            @(negedge clk);
            budget++;
            gotDm = dm_ready; gotIf = if_ready;
            if (gotDm && gotIf) check("t3 both ready", 1, 0);
            @(posedge clk); #1;
            if (gotDm) begin
                dmIdx++;
                if (dmIdx < 9) begin
                    dm_addr = 32'h10 + 32'(4 * dmIdx);
                    dm_wdata = 32'hA000_0000 + 32'(dmIdx);
                end else begin
                    dm_req = 1'b0; dm_we = 1'b0;
                end
            end
            if (gotIf) begin
                ifIdx++;
                if (ifIdx == 1) if_addr = 32'h600;
                else if_req = 1'b0;
            end
        end
        check("t3 completions", {dmIdx, ifIdx}, {32'd9, 32'd2});

        // Store, latency 3: fields held 4 cycles, one ready, rdata 0
        @(posedge clk); #1;
        memLat = 3; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        pushIssue(1'b1, 32'h40, 32'hDEAD_BEEF); pushResp(1'b1, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_en && n < 10);
        check("t4 mem_en seen", mem_en, 1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("t4 hold c%0d", k), {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h40, 32'hDEAD_BEEF});
            pulses += int'(dm_ready);
        end
        @(posedge clk); #1 dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk); pulses += int'(dm_ready);
        check("t4 one ready", pulses, 1);

        // Timeout with TIMEOUT_CYC=8
        @(posedge clk); #1;
        memMute = 1'b1; if_req = 1'b1; if_addr = 32'h700;
        pushIssue(1'b0, 32'h700, '0); pushResp(1'b0, 32'h0);
        waitReady(1'b0, 30, n);
        check("t5 timeout cycles", n, 10);
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk); check("t5 bus_err set", bus_err, 1);
        @(posedge clk); #1 staleValid = 1'b1; staleData = 32'h1234_5678;
        @(negedge clk); check("t5 stale ignored", {if_ready, dm_ready}, 0);
        @(posedge clk); #1 staleValid = 1'b0; staleData = '0;
        repeat (3) @(negedge clk);
        check("t5 bus_err sticky", bus_err, 1);
        memMute = 1'b0;

        // Reset mid-access
        @(posedge clk); #1;
        memLat = 4; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        pushIssue(1'b0, 32'h80, '0);
        @(negedge clk);
        @(negedge clk); check("t6 mem_en c1", mem_en, 1);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check("t6 outs in reset", {mem_en, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, bus_err}, '0);
        check("t6 rdata in reset", {if_rdata, dm_rdata}, '0);
        dm_req = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pulses += int'(if_ready) + int'(dm_ready) + int'(mem_en);
        end
        check("t6 quiet after reset", pulses, 0);

        @(posedge clk); #1;
        memLat = 1; if_req = 1'b1; if_addr = 32'h900;
        pushIssue(1'b0, 32'h900, '0); pushResp(1'b0, 32'hFFFF_F6FF);
        waitReady(1'b0, 20, n);
        check("t6 fetch after reset", n, 3);
        @(posedge clk); #1 if_req = 1'b0;

        repeat (3) @(negedge clk);
        check("queues drained", expIssue.size() + expResp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the instruction fetch port (IF stage) and the load/store port (MEM stage) of the pipelined core.
- Data accesses get fixed priority, with a starvation guard for fetch.
- Drives the memory handshake, returns read data and a one-cycle ready to the granted requester, and produces per-stage stall signals for the hazard logic.
- Includes a watchdog that aborts hung memory transactions.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_LIMIT, 4, number of consecutive data grants allowed while if_req is pending before fetch is forced.
- TIMEOUT_CYC, 255, cycles to wait for mem_valid after issue before aborting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with stable if_addr until if_ready.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetch read data; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  load/store request; held with stable inputs until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  load/store address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid when dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for load/store.
- mem_en  out  1  one-cycle issue strobe to memory.
- mem_we  out  1  write enable; held for the whole transaction.
- mem_addr  out  AW  registered address; held until completion.
- mem_wdata  out  DW  registered store data; held until completion.
- mem_rdata  in  DW  memory read data; valid with mem_valid.
- mem_valid  in  1  memory completion; minimum 1 cycle after mem_en.
- stall_if  out  1  if_req & ~if_ready.
- stall_mem  out  1  dm_req & ~dm_ready.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync-style deassert is not required):
  - State goes to IDLE.
  - mem_en, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, bus_err, starve counter and wait counter all go to 0.
  - if_rdata and dm_rdata read 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - If dm_req=1 and (if_req=0 or starve counter < STARVE_LIMIT): register dm_addr, dm_wdata, dm_we; pulse mem_en next cycle; go to BUSY_DM.
  - If dm_req=1, if_req=1 and starve counter = STARVE_LIMIT: grant IF instead.
  - If only if_req=1: register if_addr with mem_we=0; go to BUSY_IF.
  - If neither request is high: stay in IDLE, mem_en=0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each DM grant made while if_req=1.
  - Clears on any IF grant.
  - Clears on a DM grant while if_req=0.
- BUSY_x:
  - mem_en is high only in the first BUSY cycle.
  - mem_addr, mem_we and mem_wdata stay stable throughout.
  - The wait counter increments every cycle.
  - On mem_valid=1: the granted port's ready=1 and rdata=mem_rdata in that same cycle (combinational pass-through); state returns to IDLE.
  - A new grant can issue no earlier than the next IDLE cycle. Minimum occupancy is 3 cycles per access (grant, issue, valid).
  - The non-granted ready is always 0; its rdata reads 0.
- Timeout: if the wait counter reaches TIMEOUT_CYC without mem_valid:
  - The granted ready pulses with rdata=0.
  - bus_err is set (sticky until reset).
  - State returns to IDLE.
  - The wait counter clears on every new grant.
- mem_valid arriving in IDLE (stale response, or after a timeout or reset) is ignored.
- A store completes on mem_valid exactly like a load; dm_rdata is don't-care, driven 0.
- A requester deasserting its req mid-transaction is illegal. The transaction still completes and the ready still pulses, so no state corruption results.
- Reset mid-transaction abandons the access. No ready is pulsed and any later mem_valid is ignored.
- stall_if and stall_mem are combinational. Both may be high at once when both ports are waiting.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, memory latency 1 → mem_en at cycle 1 with mem_addr=0x100 and mem_we=0; if_ready and if_rdata=mem_rdata at cycle 2; stall_if high in cycles 0-1.
- Simultaneous requests: if_req=dm_req=1 with a load at 0x2000 → DM is granted first; dm_ready arrives, then the IF grant follows in the next IDLE cycle; stall_if stays high across both accesses.
- Starvation: dm_req held continuously with back-to-back stores and if_req=1 → exactly 4 DM grants, then 1 IF grant, then DM resumes; counter clears after the IF grant.
- Store: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, latency 3 → mem_we/mem_addr/mem_wdata held stable for 4 cycles; dm_ready pulses once; dm_rdata=0.
- Timeout: with TIMEOUT_CYC=8, memory never asserts valid → ready pulses after 8 BUSY cycles with rdata=0; bus_err=1 and stays set; a later stale mem_valid in IDLE produces no ready.
- Reset mid-access: assert reset during BUSY_DM → all outputs go to 0 immediately; after release with no requests, a mem_valid produces no ready and the state remains IDLE.
